// File: rtl/msgdma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msgdma_pkg
//  Description : Shared types and constants for the mSGDMA fetch FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package msgdma_pkg;

    localparam int STREAM_EDGE  = 0;
    localparam int STREAM_LEVEL = 1;
    localparam int PKT_CNT_W    = 16;

    // Packet flags stored ahead of the data word in every FIFO entry.
    typedef struct packed {
        logic sop;
        logic eop;
    } pkt_flags_t;

    localparam int FLAGS_W = $bits(pkt_flags_t);

endpackage
`default_nettype wire

// File: rtl/msgdma_fetch_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : msgdma_fetch_fifo_if
//  Description : Avalon-ST source channel feeding the fetch FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface msgdma_fetch_fifo_if #(
    parameter int N = 32
);
    logic [N-1:0] source_data;
    logic         source_valid;
    logic         source_startofpacket;
    logic         source_endofpacket;
    logic         source_ready;

    modport master (
        output source_data, source_valid, source_startofpacket, source_endofpacket,
        input  source_ready
    );

    modport slave (
        input  source_data, source_valid, source_startofpacket, source_endofpacket,
        output source_ready
    );
endinterface
`default_nettype wire

// File: rtl/msgdma_sfifo.sv
`default_nettype none
// ============================================================================
//  Module      : msgdma_sfifo
//  Description : Synchronous FIFO with registered read port and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module msgdma_sfifo #(
    parameter  int W     = 34,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [W-1:0]  rdata_q, rdata_d;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        rdata_d  = pop ? mem[rd_ptr_q] : rdata_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        empty_d  = (level_d == '0);
        full_d   = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = rdata_q;
    assign level = level_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule
`default_nettype wire

// File: rtl/msgdma_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : msgdma_fetch_fifo
//  Description : mSGDMA stream sink buffering words for an edge/level fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
module msgdma_fetch_fifo
    import msgdma_pkg::*;
#(
    parameter  int N      = 32,
    parameter  int DEPTH  = 16,
    parameter  int STREAM = 0,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    msgdma_fetch_fifo_if.slave   src,
    input  logic                 fetch_enable,
    output logic [N-1:0]         data,
    output logic                 data_valid,
    output logic                 data_sop,
    output logic                 data_eop,
    output logic [LW-1:0]        level,
    output logic                 empty,
    output logic                 full,
    output logic                 underrun,
    input  logic                 underrun_clr,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    typedef struct packed {
        pkt_flags_t   flags;
        logic [N-1:0] data;
    } entry_t;

    entry_t                 wr_entry;
    entry_t                 rd_entry;
    logic                   push;
    logic                   pop;
    logic                   fetch_req;
    logic                   fe_dly_q, fe_dly_d;
    logic                   data_valid_q, data_valid_d;
    logic                   underrun_q, underrun_d;
    logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;

    assign wr_entry = {src.source_startofpacket, src.source_endofpacket, src.source_data};
    assign src.source_ready = ~full;

    // No bypass: a request against an empty FIFO never pops, even if a word lands this cycle.
    always_comb begin
        fetch_req    = (STREAM == STREAM_LEVEL) ? fetch_enable : (fetch_enable & ~fe_dly_q);
        push         = src.source_valid & ~full;
        pop          = fetch_req & ~empty;
        fe_dly_d     = fetch_enable;
        data_valid_d = pop;
        underrun_d   = underrun_q;
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end
        if (fetch_req & empty) begin
            underrun_d = 1'b1;
        end
        pkt_count_d  = pkt_count_q + PKT_CNT_W'(data_valid_q & rd_entry.flags.eop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_dly_q     <= 1'b0;
            data_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            fe_dly_q     <= fe_dly_d;
            data_valid_q <= data_valid_d;
            underrun_q   <= underrun_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    msgdma_sfifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_sfifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    assign data       = rd_entry.data;
    assign data_sop   = rd_entry.flags.sop;
    assign data_eop   = rd_entry.flags.eop;
    assign data_valid = data_valid_q;
    assign underrun   = underrun_q;
    assign pkt_count  = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_msgdma_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msgdma_fetch_fifo
//  Description : Self-checking bench for msgdma_fetch_fifo in edge and stream modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msgdma_fetch_fifo;

    localparam int N     = 32;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Stimulus, index 0 = edge-mode instance, 1 = stream-mode instance
    logic         vld [2];
    logic         sop [2];
    logic         eop [2];
    logic         fe  [2];
    logic         clr [2];
    logic [N-1:0] dat [2];

    msgdma_fetch_fifo_if #(.N(N)) src0 ();
    msgdma_fetch_fifo_if #(.N(N)) src1 ();

    assign src0.source_valid         = vld[0];
    assign src0.source_data          = dat[0];
    assign src0.source_startofpacket = sop[0];
    assign src0.source_endofpacket   = eop[0];
    assign src1.source_valid         = vld[1];
    assign src1.source_data          = dat[1];
    assign src1.source_startofpacket = sop[1];
    assign src1.source_endofpacket   = eop[1];

    logic [N-1:0]  data0, data1;
    logic          dv0, dv1, dsop0, dsop1, deop0, deop1;
    logic [LW-1:0] level0, level1;
    logic          empty0, empty1, full0, full1, und0, und1;
    logic [15:0]   pkt0, pkt1;

    msgdma_fetch_fifo #(.N(N), .DEPTH(DEPTH), .STREAM(0)) u_dut_edge (
        .clk          (clk),
        .reset        (reset),
        .src          (src0),
        .fetch_enable (fe[0]),
        .data         (data0),
        .data_valid   (dv0),
        .data_sop     (dsop0),
        .data_eop     (deop0),
        .level        (level0),
        .empty        (empty0),
        .full         (full0),
        .underrun     (und0),
        .underrun_clr (clr[0]),
        .pkt_count    (pkt0)
    );

    msgdma_fetch_fifo #(.N(N), .DEPTH(DEPTH), .STREAM(1)) u_dut_strm (
        .clk          (clk),
        .reset        (reset),
        .src          (src1),
        .fetch_enable (fe[1]),
        .data         (data1),
        .data_valid   (dv1),
        .data_sop     (dsop1),
        .data_eop     (deop1),
        .level        (level1),
        .empty        (empty1),
        .full         (full1),
        .underrun     (und1),
        .underrun_clr (clr[1]),
        .pkt_count    (pkt1)
    );

    // Reference model: an ordered list of stored entries plus delivered-output state
    logic [N+1:0] mq [2][0:DEPTH+3];
    int           mcnt      [2];
    logic         m_fe_prev [2];
    logic         m_dv      [2];
    logic         m_sop     [2];
    logic         m_eop     [2];
    logic [N-1:0] m_data    [2];
    logic         m_und     [2];
    logic [15:0]  m_pkt     [2];
    logic         m_pushed  [2];

    task automatic model_reset(input int k);
        mcnt[k]      = 0;
        m_fe_prev[k] = 1'b0;
        m_dv[k]      = 1'b0;
        m_sop[k]     = 1'b0;
        m_eop[k]     = 1'b0;
        m_data[k]    = '0;
        m_und[k]     = 1'b0;
        m_pkt[k]     = 16'd0;
        m_pushed[k]  = 1'b0;
    endtask

    task automatic model_edge(input int k);
        logic req, do_push, do_pop;
        req     = (k == 1) ? fe[k] : (fe[k] && !m_fe_prev[k]);
        do_push = vld[k] && (mcnt[k] < DEPTH);
        do_pop  = req && (mcnt[k] > 0);
        if (m_dv[k] && m_eop[k]) m_pkt[k] = m_pkt[k] + 16'd1;
        if (req && mcnt[k] == 0) m_und[k] = 1'b1;
        else if (clr[k])         m_und[k] = 1'b0;
        m_dv[k] = do_pop;
        if (do_pop) begin
            {m_sop[k], m_eop[k], m_data[k]} = mq[k][0];
            for (int i = 0; i < mcnt[k] - 1; i++) mq[k][i] = mq[k][i+1];
            mcnt[k] = mcnt[k] - 1;
        end
        if (do_push) begin
            mq[k][mcnt[k]] = {sop[k], eop[k], dat[k]};
            mcnt[k] = mcnt[k] + 1;
        end
        m_pushed[k]  = do_push;
        m_fe_prev[k] = fe[k];
    endtask

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(input int k);
        logic [N-1:0]  od;
        logic          odv, os, oe, oem, ofu, ordy, ou;
        logic [LW-1:0] ol;
        logic [15:0]   op;
        if (k == 0) begin
            od = data0; odv = dv0; os = dsop0; oe = deop0; ol = level0;
            oem = empty0; ofu = full0; ordy = src0.source_ready; ou = und0; op = pkt0;
        end else begin
            od = data1; odv = dv1; os = dsop1; oe = deop1; ol = level1;
            oem = empty1; ofu = full1; ordy = src1.source_ready; ou = und1; op = pkt1;
        end
        chk("data",       k, 64'(od),   64'(m_data[k]));
        chk("data_valid", k, 64'(odv),  64'(m_dv[k]));
        chk("data_sop",   k, 64'(os),   64'(m_sop[k]));
        chk("data_eop",   k, 64'(oe),   64'(m_eop[k]));
        chk("level",      k, 64'(ol),   64'(mcnt[k]));
        chk("empty",      k, 64'(oem),  64'(mcnt[k] == 0));
        chk("full",       k, 64'(ofu),  64'(mcnt[k] == DEPTH));
        chk("ready",      k, 64'(ordy), 64'(mcnt[k] < DEPTH));
        chk("underrun",   k, 64'(ou),   64'(m_und[k]));
        chk("pkt_count",  k, 64'(op),   64'(m_pkt[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) model_reset(k);
            else       model_edge(k);
        end
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; sop[k] = 1'b0; eop[k] = 1'b0;
            fe[k]  = 1'b0; clr[k] = 1'b0; dat[k] = '0;
        end
    endtask

    // Assert reset between clock edges and check the outputs before any edge arrives
    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_all(0);
        check_all(1);
        chk("rst_level", 0, 64'(level0), 64'd0);
        chk("rst_empty", 0, 64'(empty0), 64'd1);
        chk("rst_dv",    0, 64'(dv0),    64'd0);
        #2 reset = 1'b0;
    endtask

    task automatic pulse(input int k);
        fe[k] = 1'b1; tick();
        fe[k] = 1'b0; tick();
    endtask

    initial begin
        int sent;
        int strobes;
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b1;
        model_reset(0);
        model_reset(1);
        #2;
        check_all(0);
        check_all(1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Three words fetched one per rising edge, latency one cycle
        for (int i = 0; i < 3; i++) begin
            vld[0] = 1'b1; dat[0] = 32'hA0 + i; tick();
        end
        vld[0] = 1'b0;
        chk("level_3", 0, 64'(level0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            fe[0] = 1'b1; tick();
            chk("fetch_dv",   0, 64'(dv0),   64'd1);
            chk("fetch_data", 0, 64'(data0), 64'(32'hA0 + i));
            fe[0] = 1'b0; tick();
            chk("dv_one_cycle", 0, 64'(dv0), 64'd0);
        end
        chk("level_0", 0, 64'(level0), 64'd0);

        // Overfill with valid held; words wait until space frees up
        sent = 0;
        vld[0] = 1'b1; dat[0] = $urandom;
        for (int c = 0; c < DEPTH + 4; c++) begin
            tick();
            if (m_pushed[0]) begin sent++; dat[0] = $urandom; end
        end
        chk("fill_sent",  0, 64'(sent),   64'(DEPTH));
        chk("fill_level", 0, 64'(level0), 64'(DEPTH));
        chk("fill_full",  0, 64'(full0),  64'd1);
        chk("fill_ready", 0, 64'(src0.source_ready), 64'd0);
        for (int p = 0; p < 2; p++) begin
            fe[0] = 1'b1; tick();
            if (m_pushed[0]) begin sent++; dat[0] = $urandom; end
            fe[0] = 1'b0; tick();
            if (m_pushed[0]) begin sent++; dat[0] = $urandom; end
        end
        chk("fill_sent_after_pop", 0, 64'(sent), 64'(DEPTH + 2));
        vld[0] = 1'b0;
        for (int p = 0; p < DEPTH; p++) pulse(0);
        chk("drained", 0, 64'(empty0), 64'd1);

        // Two-word packet
        vld[0] = 1'b1; sop[0] = 1'b1; dat[0] = 32'h11; tick();
        sop[0] = 1'b0; eop[0] = 1'b1; dat[0] = 32'h22; tick();
        vld[0] = 1'b0; eop[0] = 1'b0;
        chk("pkt_before", 0, 64'(pkt0), 64'd0);
        fe[0] = 1'b1; tick();
        chk("pkt_sop", 0, 64'(dsop0), 64'd1);
        fe[0] = 1'b0; tick();
        fe[0] = 1'b1; tick();
        chk("pkt_eop", 0, 64'(deop0), 64'd1);
        fe[0] = 1'b0; tick();
        chk("pkt_after", 0, 64'(pkt0), 64'd1);

        // Simultaneous push and pop at level 5
        vld[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin dat[0] = $urandom; tick(); end
        vld[0] = 1'b0; tick();
        vld[0] = 1'b1; fe[0] = 1'b1; dat[0] = 32'h55; tick();
        chk("pp_level", 0, 64'(level0), 64'd5);
        chk("pp_dv",    0, 64'(dv0),    64'd1);
        vld[0] = 1'b0; fe[0] = 1'b0; tick();
        chk("pp_dv_once", 0, 64'(dv0), 64'd0);
        for (int p = 0; p < 5; p++) pulse(0);

        // Underrun set wins over clear in the same cycle
        fe[0] = 1'b1; clr[0] = 1'b1; tick();
        chk("und_set_wins", 0, 64'(und0), 64'd1);
        fe[0] = 1'b0; clr[0] = 1'b0; tick();
        clr[0] = 1'b1; tick();
        chk("und_clr", 0, 64'(und0), 64'd0);
        clr[0] = 1'b0;

        // Stream mode: four stored words, fetch held six cycles
        vld[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin dat[1] = 32'hB0 + i; tick(); end
        vld[1] = 1'b0;
        strobes = 0;
        fe[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin tick(); strobes += int'(dv1); end
        fe[1] = 1'b0; tick(); strobes += int'(dv1);
        chk("strm_strobes", 1, 64'(strobes), 64'd4);
        chk("strm_und",     1, 64'(und1),    64'd1);
        clr[1] = 1'b1; tick();
        chk("strm_und_clr", 1, 64'(und1), 64'd0);
        clr[1] = 1'b0;

        // Random traffic on both instances
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                vld[k] = ($urandom_range(0, 2) != 0);
                sop[k] = ($urandom_range(0, 3) == 0);
                eop[k] = ($urandom_range(0, 3) == 0);
                dat[k] = $urandom;
                fe[k]  = ($urandom_range(0, 2) == 0);
                clr[k] = ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        idle();
        tick();

        // Reset asserted mid-packet with level 7 and a strobe in flight
        async_reset();
        vld[0] = 1'b1; sop[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin dat[0] = 32'hC0 + i; tick(); sop[0] = 1'b0; end
        vld[0] = 1'b0;
        fe[0] = 1'b1; tick();
        fe[0] = 1'b0;
        chk("pre_rst_level", 0, 64'(level0), 64'd7);
        chk("pre_rst_dv",    0, 64'(dv0),    64'd1);
        async_reset();
        fe[0] = 1'b1; tick();
        chk("post_rst_und", 0, 64'(und0), 64'd1);
        fe[0] = 1'b0; tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msgdma_fetch_fifo.md
MSGDMA_FETCH_FIFO -- requirements
Module: msgdma_fetch_fifo

Interface
REQ-001 Parameter N, default 32: data word width in bits; legal range 8..512.
REQ-002 Parameter DEPTH, default 16: FIFO depth in words; power of two, 4..1024.
REQ-003 Parameter STREAM, default 0: 0 = one word popped per fetch_enable rising edge; 1 = one word popped per cycle while fetch_enable is high.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port source_data, input, N: mSGDMA Avalon-ST data.
REQ-007 Port source_valid, input, 1: source word valid.
REQ-008 Port source_startofpacket, input, 1: first word of packet.
REQ-009 Port source_endofpacket, input, 1: last word of packet.
REQ-010 Port source_ready, output, 1: sink can accept a word.
REQ-011 Port fetch_enable, input, 1: consumer fetch request.
REQ-012 Port data, output, N: fetched word.
REQ-013 Port data_valid, output, 1: one-cycle strobe, data is valid.
REQ-014 Port data_sop / data_eop, output, 1 each: packet flags travelling with data.
REQ-015 Port level, output, $clog2(DEPTH)+1: words currently stored.
REQ-016 Port empty / full, output, 1 each: FIFO status.
REQ-017 Port underrun, output, 1: sticky; set when a pop is requested while empty.
REQ-018 Port underrun_clr, input, 1: synchronous clear of underrun.
REQ-019 Port pkt_count, output, 16: number of data_eop words delivered, wrapping.

Function
REQ-020 source_ready SHALL equal ~full combinationally; push occurs on any cycle with source_valid & source_ready.
REQ-021 Each push SHALL store {sop, eop, source_data} as one N+2-bit entry.
REQ-022 The fetch request SHALL be rising-edge detected with a registered fetch_enable_d when STREAM=0, and level-sensitive when STREAM=1.
REQ-023 A pop SHALL occur when a request is present and empty=0 in the same cycle.
REQ-024 On a pop, data, data_sop and data_eop SHALL update on the next edge and data_valid SHALL be high for exactly that one cycle (latency 1 from the request edge).
REQ-025 data, data_sop and data_eop SHALL hold their last value while data_valid=0.
REQ-026 A request with empty=1 SHALL NOT pop and SHALL set underrun, even if a push occurs in the same cycle; there is no bypass path.
REQ-027 A simultaneous push and pop SHALL leave level unchanged.
REQ-028 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 full SHALL be (level==DEPTH) and empty SHALL be (level==0), both registered consistently with level.
REQ-030 pkt_count SHALL increment when data_valid & data_eop, and wrap from 0xFFFF to 0.
REQ-031 When underrun_clr and a new underrun occur in the same cycle, the set SHALL win.
REQ-032 Packet flags are passed through unchecked; a missing sop or eop SHALL NOT alter behaviour.

Reset
REQ-033 Asserting reset SHALL immediately clear pointers, level, data_valid, data_sop, data_eop, underrun, pkt_count and fetch_enable_d; data SHALL reset to 0.
REQ-034 During reset, empty=1, full=0 and source_ready=1; reset asserted mid-packet SHALL discard all stored words.
REQ-035 Memory contents SHALL NOT require reset.

Structure
REQ-036 Package msgdma_pkg SHALL hold the entry typedef (sop, eop, data), the STREAM mode constants and the pkt_count width.
REQ-037 Storage and pointers SHALL live in one sub-module, msgdma_sfifo (synchronous FIFO, registered read); fetch logic and counters stay in the top level.

Verification
REQ-038 Push 3 words 0xA0..0xA2, then 3 fetch_enable pulses with STREAM=0 -> data 0xA0, 0xA1, 0xA2, each data_valid one cycle after the edge; level 3→0.
REQ-039 Push DEPTH+2 words with source_valid held high -> source_ready low after 16 words, full=1, level=16; words 17–18 accepted only after pops.
REQ-040 STREAM=1 with 4 words stored and fetch_enable high for 6 cycles -> 4 consecutive data_valid strobes, then underrun=1; underrun_clr → 0.
REQ-041 Push a 2-word packet (sop on word 1, eop on word 2) and fetch both -> data_sop=1 then data_eop=1; pkt_count increments 0→1.
REQ-042 Push and pop in the same cycle with level=5 -> level stays 5 and data_valid pulses once.
REQ-043 Assert reset asynchronously with level=7 mid-packet -> level=0, empty=1, data_valid=0 without a clock edge; post-reset fetch_enable sets underrun.
